sumator_8bit: RTL and testbench

//   8-bit binary adder with carry-in and carry-out, registered at the output.

---
 rtl/sumator_8bit_if.sv | 27 ++
 rtl/sumator_8bit.sv | 41 ++++
 tb/tb_sumator_8bit.sv | 114 +++++++++++
 3 files changed

// File: rtl/sumator_8bit_if.sv
// Operand/result bundle for sumator_8bit: the operand side drives the inputs,
// the adder drives the registered sum and carry.
interface sumator_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             carry_in;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out;
    logic             carry_out;

    modport master (
        output carry_in,
        output in0,
        output in1,
        input  out,
        input  carry_out
    );

    modport slave (
        input  carry_in,
        input  in0,
        input  in1,
        output out,
        output carry_out
    );
endinterface

// File: rtl/sumator_8bit.sv
// Unsigned adder with carry-in/carry-out: a ripple chain of full adders feeding
// an output register, one cycle of latency, a new operation every cycle.
module sumator_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    sumator_8bit_if.slave bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] out_d, out_q;
    logic             carry_d, carry_q;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = bus.carry_in;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = bus.in0[i] ^ bus.in1[i] ^ carry[i];
            carry[i+1] = (bus.in0[i] & bus.in1[i]) | (carry[i] & (bus.in0[i] ^ bus.in1[i]));
        end
    end

    always_comb begin
        out_d   = sum;
        carry_d = carry[WIDTH];
        if (rst) begin
            out_d   = '0;
            carry_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        out_q   <= out_d;
        carry_q <= carry_d;
    end

    assign bus.out       = out_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_sumator_8bit.sv
// Directed-vector table plus reset, registered-output and random back-to-back
// sequences for sumator_8bit, checked against hand-computed and modelled results.
module tb_sumator_8bit;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    sumator_8bit_if #(.WIDTH(8)) bus ();

    sumator_8bit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ci;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_out;
        logic       exp_c;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [7:0] exp_out, input logic exp_c);
        n_vec++;
        if (bus.out !== exp_out || bus.carry_out !== exp_c) begin
            n_bad++;
            $display("FAIL %s: got out=%h carry_out=%b, want out=%h carry_out=%b",
                     name, bus.out, bus.carry_out, exp_out, exp_c);
        end
    endtask

    task automatic drive(input logic ci, input logic [7:0] a, input logic [7:0] b);
        bus.carry_in = ci;
        bus.in0      = a;
        bus.in1      = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] model;
        logic [8:0] exp_q;
        logic       ci;
        logic [7:0] a, b;

        n_vec = 0;
        n_bad = 0;

        vecs[0] = '{1'b0, 8'h22, 8'h99, 8'hBB, 1'b0};
        vecs[1] = '{1'b1, 8'h53, 8'h29, 8'h7D, 1'b0};
        vecs[2] = '{1'b0, 8'h6D, 8'hC5, 8'h32, 1'b1};
        vecs[3] = '{1'b1, 8'h95, 8'h85, 8'h1B, 1'b1};
        vecs[4] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 8'h00, 8'h01, 1'b0};
        vecs[8] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[9] = '{1'b1, 8'h7F, 8'h80, 8'h00, 1'b1};

        // Reset for two edges with all-ones inputs that would otherwise give 1FF.
        rst = 1'b1;
        drive(1'b1, 8'hFF, 8'hFF);
        step();
        check("reset_edge1", 8'h00, 1'b0);
        step();
        check("reset_edge2", 8'h00, 1'b0);

        // First result follows the inputs sampled on the edge after deassert.
        rst = 1'b0;
        drive(1'b0, 8'h22, 8'h99);
        step();
        check("after_reset", 8'hBB, 1'b0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ci, vecs[i].a, vecs[i].b);
            step();
            check($sformatf("table[%0d]", i), vecs[i].exp_out, vecs[i].exp_c);
        end

        // Output must not follow inputs between edges.
        drive(1'b1, 8'h01, 8'h01);
        #3;
        check("no_comb_path", 8'h00, 1'b1);
        step();
        check("comb_then_edge", 8'h03, 1'b0);

        // Back-to-back random vectors with a reset mid-stream.
        for (int i = 0; i < 1000; i++) begin
            ci = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            drive(ci, a, b);
            model = {1'b0, a} + {1'b0, b} + {8'd0, ci};
            rst = (i == 500);
            exp_q = rst ? 9'd0 : model;
            step();
            check($sformatf("rand[%0d]", i), exp_q[7:0], exp_q[8]);
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
